// File: rtl/ccsds_turbo_pkg.sv
// rtl/ccsds_turbo_pkg.sv - shared constants and types for the turbo frame buffer
//
// Purpose: CCSDS turbo information-block lengths and the read-FSM state type.
// Ports:   none (package).
package ccsds_turbo_pkg;

  localparam int K_1784 = 1784;
  localparam int K_3568 = 3568;
  localparam int K_7136 = 7136;
  localparam int K_8920 = 8920;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/ccsds_frame_buf_ram.sv
// rtl/ccsds_frame_buf_ram.sv - simple dual-port frame storage, registered read
//
// Purpose: DEPTH x DATA_W storage with one write port and one read port whose
//          data register is loaded one cycle after rd_en_i.
// Ports:   clk, rst         clock, synchronous active-high reset (read reg only)
//          wr_en_i          write enable
//          wr_addr_i        write address
//          wr_data_i        write data
//          rd_en_i          read enable
//          rd_addr_i        read address
//          rd_data_o        registered read data
module ccsds_frame_buf_ram #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 2,
  parameter int AW     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage array is never cleared; only the output register is reset so the
  // read port presents zero after reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ccsds_turbo_frame_buf.sv
// rtl/ccsds_turbo_frame_buf.sv - multi-slot frame buffer between turbo stages
//
// Purpose: collects variable-length frames into FRAMES slots of K_MAX words,
//          then replays each committed frame as a burst when the downstream
//          RAM is free. Optional macro CCSDS_FRAME_DROP_EN drops a whole frame
//          on overflow instead of discarding word by word.
// Ports:   clk, rst          clock, synchronous active-high reset
//          i_data            write word
//          i_data_en         write strobe
//          i_data_in_ctrl    write gate (word accepted on en & ctrl)
//          i_frame_len       frame length, sampled on first word of a frame
//          i_ram_busy        downstream busy, sampled only while idle
//          o_data            read word
//          o_data_valid      o_data qualifier
//          o_frame_start     first valid word of a frame
//          o_frame_end       last valid word of a frame
//          o_frame_cnt       committed, unread frames
//          o_overflow        pulse: accepted word discarded for lack of a slot
//          o_len_err         pulse: illegal i_frame_len on a first word
module ccsds_turbo_frame_buf
  import ccsds_turbo_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int K_MAX  = 8920,
  parameter int FRAMES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_data_en,
  input  logic                         i_data_in_ctrl,
  input  logic [$clog2(K_MAX+1)-1:0]   i_frame_len,
  input  logic                         i_ram_busy,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_data_valid,
  output logic                         o_frame_start,
  output logic                         o_frame_end,
  output logic [$clog2(FRAMES+1)-1:0]  o_frame_cnt,
  output logic                         o_overflow,
  output logic                         o_len_err
);

  localparam int LW    = $clog2(K_MAX + 1);
  localparam int CW    = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int SW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int FCW   = $clog2(FRAMES + 1);
  localparam int DEPTH = FRAMES * K_MAX;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
    return (s == SW'(FRAMES - 1)) ? '0 : s + SW'(1);
  endfunction

  // Write side state
  logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [SW-1:0]  wr_slot_q, wr_slot_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           ovf_q, ovf_d;
  logic           len_err_q, len_err_d;
  logic [LW-1:0]  len_tab [FRAMES];

  // Read side state
  rd_state_e      state_q;
  logic [CW-1:0]  rd_cnt_q;
  logic [SW-1:0]  rd_slot_q;
  logic           valid_q, start_q, end_q;

  logic           accept, first, len_ok, full, wr_en, commit, drop_busy;
  logic [LW-1:0]  cur_len, rd_len;
  logic           rd_en, rd_last;
  logic [AW-1:0]  wr_addr, rd_addr;

  assign accept = i_data_en & i_data_in_ctrl;

`ifdef CCSDS_FRAME_DROP_EN
  // Remaining words of a frame being thrown away after an overflowed first
  // word; keeps the writer aligned to frame boundaries.
  logic [LW-1:0] drop_rem_q, drop_rem_d;

  assign drop_busy = (drop_rem_q != '0);

  always_comb begin
    drop_rem_d = drop_rem_q;
    if (accept && drop_busy) begin
      drop_rem_d = drop_rem_q - LW'(1);
    end else if (ovf_d) begin
      drop_rem_d = i_frame_len - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_rem_q <= '0;
    end else begin
      drop_rem_q <= drop_rem_d;
    end
  end
`else
  assign drop_busy = 1'b0;
`endif

  always_comb begin
    first     = (wr_cnt_q == '0);
    len_ok    = (i_frame_len != '0) && (i_frame_len <= LW'(K_MAX));
    full      = (frame_cnt_q == FCW'(FRAMES));
    cur_len   = first ? i_frame_len : len_tab[wr_slot_q];
    wr_en     = 1'b0;
    len_err_d = 1'b0;
    ovf_d     = 1'b0;
    // A frame in progress always has a free slot, so only first words are
    // checked for length and space.
    if (accept && !drop_busy) begin
      if (!first) begin
        wr_en = 1'b1;
      end else if (!len_ok) begin
        len_err_d = 1'b1;
      end else if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
      end
    end
    commit    = wr_en && (LW'(wr_cnt_q) == cur_len - LW'(1));
    wr_cnt_d  = commit ? '0 : (wr_en ? wr_cnt_q + CW'(1) : wr_cnt_q);
    wr_slot_d = commit ? slot_inc(wr_slot_q) : wr_slot_q;
    // Commit and release in the same cycle cancel out.
    frame_cnt_d = frame_cnt_q;
    if (commit && !rd_last) begin
      frame_cnt_d = frame_cnt_q + FCW'(1);
    end else if (!commit && rd_last) begin
      frame_cnt_d = frame_cnt_q - FCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_slot_q   <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_slot_q   <= wr_slot_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      len_err_q   <= len_err_d;
    end
  end

  // Length table is written alongside the first word; stale entries after a
  // reset are harmless because no frame is committed.
  always_ff @(posedge clk) begin
    if (wr_en && first) begin
      len_tab[wr_slot_q] <= i_frame_len;
    end
  end

  assign rd_len  = len_tab[rd_slot_q];
  assign rd_en   = (state_q == READ);
  assign rd_last = rd_en && (LW'(rd_cnt_q) == rd_len - LW'(1));
  assign wr_addr = AW'(wr_slot_q) * AW'(K_MAX) + AW'(wr_cnt_q);
  assign rd_addr = AW'(rd_slot_q) * AW'(K_MAX) + AW'(rd_cnt_q);

  // Read FSM. Flags are registered in step with the RAM's read register.
  // Returning to IDLE after the last read gives the mandatory idle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      rd_slot_q <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      valid_q <= rd_en;
      start_q <= rd_en && (rd_cnt_q == '0);
      end_q   <= rd_last;
      case (state_q)
        IDLE: begin
          if ((frame_cnt_q != '0) && !i_ram_busy) begin
            state_q  <= READ;
            rd_cnt_q <= '0;
          end
        end
        READ: begin
          if (rd_last) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            rd_slot_q <= slot_inc(rd_slot_q);
          end else begin
            rd_cnt_q <= rd_cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  ccsds_frame_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (i_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (o_data)
  );

  assign o_data_valid  = valid_q;
  assign o_frame_start = start_q;
  assign o_frame_end   = end_q;
  assign o_frame_cnt   = frame_cnt_q;
  assign o_overflow    = ovf_q;
  assign o_len_err     = len_err_q;

endmodule

// File: tb/tb_ccsds_turbo_frame_buf.sv
// tb/tb_ccsds_turbo_frame_buf.sv - self-checking bench for ccsds_turbo_frame_buf
module tb_ccsds_turbo_frame_buf;

  localparam int K   = 16;
  localparam int F   = 2;
  localparam int LW  = 5;
  localparam int FCW = 2;
`ifdef CCSDS_FRAME_DROP_EN
  localparam int EXP_OVF = 1;
`else
  localparam int EXP_OVF = 8;
`endif

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
    int         cyc;
  } smp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic d, en, ctrl, busy;
  logic [LW-1:0] flen;
  logic od, ov, os, oe, oovf, olerr;
  logic [FCW-1:0] ocnt;

  logic [7:0] d8, od8;
  logic en8, ctrl8, busy8, ov8, os8, oe8, oovf8, olerr8;
  logic [LW-1:0] flen8;
  logic [FCW-1:0] ocnt8;

  smp_t obs[$], obs8[$], exp_q[$], exp8_q[$];
  int cyc, ovf_cnt, lerr_cnt;
  int checks, errors;

  ccsds_turbo_frame_buf #(.DATA_W(1), .K_MAX(K), .FRAMES(F)) dut (
    .clk(clk), .rst(rst), .i_data(d), .i_data_en(en), .i_data_in_ctrl(ctrl),
    .i_frame_len(flen), .i_ram_busy(busy), .o_data(od), .o_data_valid(ov),
    .o_frame_start(os), .o_frame_end(oe), .o_frame_cnt(ocnt),
    .o_overflow(oovf), .o_len_err(olerr)
  );

  ccsds_turbo_frame_buf #(.DATA_W(8), .K_MAX(K), .FRAMES(F)) dut8 (
    .clk(clk), .rst(rst), .i_data(d8), .i_data_en(en8), .i_data_in_ctrl(ctrl8),
    .i_frame_len(flen8), .i_ram_busy(busy8), .o_data(od8), .o_data_valid(ov8),
    .o_frame_start(os8), .o_frame_end(oe8), .o_frame_cnt(ocnt8),
    .o_overflow(oovf8), .o_len_err(olerr8)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    smp_t t;
    if (ov === 1'b1) begin
      t.d = {7'b0, od}; t.s = os; t.e = oe; t.cyc = cyc;
      obs.push_back(t);
    end
    if (ov8 === 1'b1) begin
      t.d = od8; t.s = os8; t.e = oe8; t.cyc = cyc;
      obs8.push_back(t);
    end
    if (oovf === 1'b1) ovf_cnt++;
    if (olerr === 1'b1) lerr_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_frame(input int len, input bit push_exp);
    smp_t t;
    logic b;
    for (int i = 0; i < len; i++) begin
      b = 1'($urandom);
      d = b; flen = 5'(len); en = 1'b1; ctrl = 1'b1;
      if (push_exp) begin
        t.d = {7'b0, b}; t.s = (i == 0); t.e = (i == len - 1); t.cyc = 0;
        exp_q.push_back(t);
      end
      @(posedge clk); #1;
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; d = 1'b0; en = 1'b0; ctrl = 1'b0; flen = '0; busy = 1'b0;
    d8 = '0; en8 = 1'b0; ctrl8 = 1'b1; flen8 = '0; busy8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ov, os, oe, od, oovf, olerr} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000", {ov, os, oe, od, oovf, olerr});
    end
    checks++;
    if (ocnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt: got %0d expected 0", ocnt);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    smp_t e, o;
    busy = 1'b0;
    send_frame(16, 1'b1);
    checks++;
    if (ocnt !== 2'd1) begin
      errors++; $display("FAIL single_cnt_commit: got %0d expected 1", ocnt);
    end
    checks++;
    if (ov !== 1'b0) begin
      errors++; $display("FAIL single_early_valid0: got %b expected 0", ov);
    end
    @(posedge clk); #1;
    checks++;
    if (ov !== 1'b0) begin
      errors++; $display("FAIL single_early_valid1: got %b expected 0", ov);
    end
    @(posedge clk); #1;
    checks++;
    if (ov !== 1'b1 || os !== 1'b1) begin
      errors++; $display("FAIL single_latency: got valid=%b start=%b expected 1 1", ov, os);
    end
    for (int i = 0; i < 100 && obs.size() < 16; i++) begin @(posedge clk); #1; end
    checks++;
    if (obs.size() !== 16) begin
      errors++; $display("FAIL single_count: got %0d words expected 16", obs.size());
    end
    checks++;
    if (ocnt !== 2'd0) begin
      errors++; $display("FAIL single_cnt_release: got %0d expected 0", ocnt);
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front(); o = obs.pop_front(); checks++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e) begin
        errors++;
        $display("FAIL single_word: got d=%0h s=%b e=%b expected d=%0h s=%b e=%b", o.d, o.s, o.e, e.d, e.s, e.e);
      end
    end
    exp_q.delete(); obs.delete();
  endtask

  task automatic test_overflow();
    smp_t e, o;
    busy = 1'b1; ovf_cnt = 0;
    send_frame(8, 1'b1);
    send_frame(8, 1'b1);
    send_frame(8, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (ocnt !== 2'd2) begin
      errors++; $display("FAIL ovf_cnt_full: got %0d expected 2", ocnt);
    end
    checks++;
    if (ovf_cnt !== EXP_OVF) begin
      errors++; $display("FAIL ovf_pulses: got %0d expected %0d", ovf_cnt, EXP_OVF);
    end
    checks++;
    if (obs.size() !== 0) begin
      errors++; $display("FAIL ovf_busy_hold: got %0d words expected 0", obs.size());
    end
    busy = 1'b0;
    for (int i = 0; i < 50 && obs.size() < 1; i++) begin @(posedge clk); #1; end
    busy = 1'b1;
    for (int i = 0; i < 50 && obs.size() < 8; i++) begin @(posedge clk); #1; end
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (obs.size() !== 8 || ocnt !== 2'd1) begin
      errors++; $display("FAIL busy_mid_read: got %0d words cnt=%0d expected 8 words cnt=1", obs.size(), ocnt);
    end
    busy = 1'b0;
    send_frame(3, 1'b1);
    for (int i = 0; i < 100 && obs.size() < 19; i++) begin @(posedge clk); #1; end
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (obs.size() !== 19 || ocnt !== 2'd0) begin
      errors++; $display("FAIL ovf_drain: got %0d words cnt=%0d expected 19 words cnt=0", obs.size(), ocnt);
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front(); o = obs.pop_front(); checks++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e) begin
        errors++;
        $display("FAIL ovf_word: got d=%0h s=%b e=%b expected d=%0h s=%b e=%b", o.d, o.s, o.e, e.d, e.s, e.e);
      end
    end
    exp_q.delete(); obs.delete();
  endtask

  task automatic test_len_err();
    smp_t e, o;
    busy = 1'b0; lerr_cnt = 0;
    d = 1'b1; flen = 5'd0; en = 1'b1; ctrl = 1'b0;
    @(posedge clk); #1;
    ctrl = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    flen = 5'd17; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (lerr_cnt !== 2) begin
      errors++; $display("FAIL len_err_pulses: got %0d expected 2", lerr_cnt);
    end
    checks++;
    if (ocnt !== 2'd0 || obs.size() !== 0) begin
      errors++; $display("FAIL len_err_no_commit: got cnt=%0d words=%0d expected 0 0", ocnt, obs.size());
    end
    send_frame(2, 1'b1);
    for (int i = 0; i < 50 && obs.size() < 2; i++) begin @(posedge clk); #1; end
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (obs.size() !== 2) begin
      errors++; $display("FAIL len_err_recover: got %0d words expected 2", obs.size());
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front(); o = obs.pop_front(); checks++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e) begin
        errors++;
        $display("FAIL len_err_word: got d=%0h s=%b e=%b expected d=%0h s=%b e=%b", o.d, o.s, o.e, e.d, e.s, e.e);
      end
    end
    exp_q.delete(); obs.delete();
  endtask

  task automatic test_back_to_back();
    smp_t e, o;
    int gap;
    busy = 1'b0;
    send_frame(4, 1'b1);
    send_frame(5, 1'b1);
    checks++;
    if (ocnt !== 2'd1) begin
      errors++; $display("FAIL commit_release_cnt: got %0d expected 1", ocnt);
    end
    for (int i = 0; i < 60 && obs.size() < 9; i++) begin @(posedge clk); #1; end
    checks++;
    if (obs.size() !== 9 || ocnt !== 2'd0) begin
      errors++; $display("FAIL b2b_count: got %0d words cnt=%0d expected 9 words cnt=0", obs.size(), ocnt);
    end else begin
      gap = obs[4].cyc - obs[3].cyc;
      checks++;
      if (gap !== 2) begin
        errors++; $display("FAIL b2b_idle_gap: got %0d cycles expected 2", gap);
      end
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front(); o = obs.pop_front(); checks++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e) begin
        errors++;
        $display("FAIL b2b_word: got d=%0h s=%b e=%b expected d=%0h s=%b e=%b", o.d, o.s, o.e, e.d, e.s, e.e);
      end
    end
    exp_q.delete(); obs.delete();
  endtask

  task automatic test_reset_mid();
    smp_t e, o;
    busy = 1'b0;
    send_frame(16, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 3; i++) begin
      d = 1'($urandom); flen = 5'd8; en = 1'b1; ctrl = 1'b1;
      @(posedge clk); #1;
    end
    d = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ov, os, oe, od, oovf, olerr} !== 6'b0 || ocnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: got outs=%b cnt=%0d expected 000000 0", {ov, os, oe, od, oovf, olerr}, ocnt);
    end
    rst = 1'b0; en = 1'b0;
    checks++;
    if (obs.size() !== 4) begin
      errors++; $display("FAIL reset_mid_words: got %0d words expected 4", obs.size());
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front(); o = obs.pop_front(); checks++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e) begin
        errors++;
        $display("FAIL reset_mid_pre: got d=%0h s=%b e=%b expected d=%0h s=%b e=%b", o.d, o.s, o.e, e.d, e.s, e.e);
      end
    end
    exp_q.delete(); obs.delete();
    @(posedge clk); #1;
    send_frame(6, 1'b1);
    for (int i = 0; i < 50 && obs.size() < 6; i++) begin @(posedge clk); #1; end
    repeat (20) begin @(posedge clk); #1; end
    checks++;
    if (obs.size() !== 6 || ocnt !== 2'd0) begin
      errors++; $display("FAIL reset_fresh: got %0d words cnt=%0d expected 6 words cnt=0", obs.size(), ocnt);
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front(); o = obs.pop_front(); checks++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e) begin
        errors++;
        $display("FAIL reset_fresh_word: got d=%0h s=%b e=%b expected d=%0h s=%b e=%b", o.d, o.s, o.e, e.d, e.s, e.e);
      end
    end
    exp_q.delete(); obs.delete();
  endtask

  task automatic test_len1_wide();
    smp_t e, o;
    int gap;
    busy8 = 1'b0; obs8.delete();
    d8 = 8'hA5; flen8 = 5'd1; en8 = 1'b1;
    e.d = 8'hA5; e.s = 1'b1; e.e = 1'b1; e.cyc = 0; exp8_q.push_back(e);
    @(posedge clk); #1;
    d8 = 8'h3C;
    e.d = 8'h3C; exp8_q.push_back(e);
    @(posedge clk); #1;
    en8 = 1'b0;
    for (int i = 0; i < 50 && obs8.size() < 2; i++) begin @(posedge clk); #1; end
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (obs8.size() !== 2 || ocnt8 !== 2'd0) begin
      errors++; $display("FAIL len1_count: got %0d words cnt=%0d expected 2 words cnt=0", obs8.size(), ocnt8);
    end else begin
      gap = obs8[1].cyc - obs8[0].cyc;
      checks++;
      if (gap !== 2) begin
        errors++; $display("FAIL len1_gap: got %0d cycles expected 2", gap);
      end
    end
    while (exp8_q.size() > 0 && obs8.size() > 0) begin
      e = exp8_q.pop_front(); o = obs8.pop_front(); checks++;
      if (o.d !== e.d || o.s !== e.s || o.e !== e.e) begin
        errors++;
        $display("FAIL len1_word: got d=%0h s=%b e=%b expected d=%0h s=%b e=%b", o.d, o.s, o.e, e.d, e.s, e.e);
      end
    end
    exp8_q.delete(); obs8.delete();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; ovf_cnt = 0; lerr_cnt = 0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_len_err();
    test_back_to_back();
    test_reset_mid();
    test_len1_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
